// File: rtl/expr_pkg.sv
// Shared definitions for the expression character path.
// Holds the transmitter state encoding, the ASCII characters used on the
// expression stream, the operator bit encoding, and two small helpers that
// map operands/operators to their characters. The string recogniser on the
// receiving side imports the same package so both ends agree on the alphabet.
package expr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIGIT,
    OP,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] CH_NUL  = 8'h00;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_PLUS = 1'b0;
  localparam logic OP_STAR = 1'b1;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_STAR) ? CH_STAR : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_req_check.sv
// Combinational validation of an expression request.
// Ports:
//   num_terms - number of operands requested (legal 1..MAX_TERMS)
//   digits    - packed BCD operands, term i at [4i+3:4i]
//   ok        - high when the term count is legal and every used operand is 0..9
// Operands at or beyond num_terms are don't-care and never cause rejection.
module expr_req_check #(
  parameter int MAX_TERMS = 8
) (
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  output logic                   ok
);

  always_comb begin
    ok = (num_terms != 4'd0) && (32'(num_terms) <= 32'(MAX_TERMS));
    for (int unsigned i = 0; i < 32'(MAX_TERMS); i++) begin
      if ((i < 32'(num_terms)) && (digits[4*i +: 4] > 4'd9)) ok = 1'b0;
    end
  end

endmodule

// File: rtl/expr_string_tx.sv
// Serialising transmitter for digit/operator expression strings.
// A validated request is latched in one handshake and sent as ASCII, one
// character per clock: digit, operator, digit, ... (2*num_terms-1 characters),
// followed by a one-cycle done pulse. Rejected requests give a one-cycle err.
// Ports:
//   clk, clr  - rising-edge clock, asynchronous active-high reset
//   start     - transmit request, only honoured in IDLE
//   num_terms - operand count; digits - BCD operands; ops - operator bits
//   hold      - downstream stall, freezes the transfer while high
//   ch/ch_valid - character out (NUL when not valid)
//   busy      - transfer or status cycle in progress
//   done, err - one-cycle completion / rejection pulses
// All outputs are registered.
module expr_string_tx
  import expr_pkg::*;
#(
  parameter  int MAX_TERMS = 8,
  localparam int IDX_W     = $clog2(MAX_TERMS)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-1:0]   ops,
  input  logic                   hold,
  output logic [7:0]             ch,
  output logic                   ch_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                 state_q, state_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [3:0]             nt_q, nt_n;
  logic [4*MAX_TERMS-1:0] digits_q, digits_n;
  logic [MAX_TERMS-1:0]   ops_q, ops_n;
  logic                   req_ok;
  logic                   stall;
  logic [7:0]             ch_d;
  logic                   valid_d;

  expr_req_check #(.MAX_TERMS(MAX_TERMS)) u_check (
    .num_terms (num_terms),
    .digits    (digits),
    .ok        (req_ok)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nt_q     <= '0;
      digits_q <= '0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      nt_q     <= nt_n;
      digits_q <= digits_n;
      ops_q    <= ops_n;
    end
  end

  // The state names the character currently on the line. A stall keeps the
  // state but blanks the line, so on release the state advances to the
  // following character: the one already shown is neither repeated nor lost.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    nt_n     = nt_q;
    digits_n = digits_q;
    ops_n    = ops_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_ok) begin
            state_n  = DIGIT;
            idx_n    = '0;
            nt_n     = num_terms;
            digits_n = digits;
            ops_n    = ops;
          end else begin
            state_n = ERR;
          end
        end
      end
      DIGIT: begin
        if (hold)                          stall   = 1'b1;
        else if (4'(idx_q) == nt_q - 4'd1) state_n = DONE;
        else                               state_n = OP;
      end
      OP: begin
        if (hold) begin
          stall = 1'b1;
        end else begin
          idx_n   = idx_q + IDX_W'(1);
          state_n = DIGIT;
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values are derived from the next state so they can be registered
  // and still appear in the cycle right after the deciding edge.
  always_comb begin
    ch_d    = CH_NUL;
    valid_d = 1'b0;
    if (!stall) begin
      case (state_n)
        DIGIT: begin
          ch_d    = digit_char(digits_n[4*idx_n +: 4]);
          valid_d = 1'b1;
        end
        OP: begin
          ch_d    = op_char(ops_n[idx_n]);
          valid_d = 1'b1;
        end
        default: begin
          ch_d    = CH_NUL;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ch       <= CH_NUL;
      ch_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ch       <= ch_d;
      ch_valid <= valid_d;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_expr_string_tx.sv
module tb_expr_string_tx;

  localparam int MAXT = 8;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            start = 1'b0;
  logic [3:0]      num_terms = '0;
  logic [4*MAXT-1:0] digits = '0;
  logic [MAXT-1:0] ops = '0;
  logic            hold = 1'b0;
  logic [7:0]      ch;
  logic            ch_valid, busy, done, err;

  expr_string_tx #(.MAX_TERMS(MAXT)) dut (
    .clk(clk), .clr(clr), .start(start), .num_terms(num_terms),
    .digits(digits), .ops(ops), .hold(hold),
    .ch(ch), .ch_valid(ch_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is a queue of characters built from the request; each edge
  // either pops one character, stalls, or reports completion.
  typedef enum {M_IDLE, M_SEND, M_FIN, M_REJ} mphase_t;
  mphase_t     mph = M_IDLE;
  byte unsigned mq[$];
  logic [7:0]  e_ch = '0;
  logic        e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

  function automatic bit legal(input logic [3:0] nt, input logic [31:0] dg);
    if (nt == 0 || int'(nt) > MAXT) return 1'b0;
    for (int i = 0; i < int'(nt); i++)
      if (((dg >> (4*i)) & 32'hF) > 32'd9) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq.delete();
      mph = M_IDLE;
      e_ch = 8'h00; e_valid = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_ch = 8'h00; e_valid = 0; e_busy = 0; e_done = 0; e_err = 0;
      case (mph)
        M_IDLE: if (start) begin
          e_busy = 1;
          if (legal(num_terms, digits)) begin
            mq.delete();
            for (int i = 0; i < int'(num_terms); i++) begin
              mq.push_back(8'(8'h30 + ((digits >> (4*i)) & 32'hF)));
              if (i < int'(num_terms) - 1) mq.push_back(ops[i] ? 8'h2A : 8'h2B);
            end
            e_ch = mq.pop_front();
            e_valid = 1;
            mph = M_SEND;
          end else begin
            e_err = 1;
            mph = M_REJ;
          end
        end
        M_SEND: begin
          e_busy = 1;
          if (!hold) begin
            if (mq.size() == 0) begin
              e_done = 1;
              mph = M_FIN;
            end else begin
              e_ch = mq.pop_front();
              e_valid = 1;
            end
          end
        end
        default: mph = M_IDLE;
      endcase
    end
  end

  // ---------------- compare process ----------------
  byte unsigned cap[$];
  int n_done = 0, n_err = 0, n_stall = 0;

  always @(negedge clk) begin
    chk("ch", 32'(ch), 32'(e_ch));
    chk("ch_valid", 32'(ch_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    if (ch_valid) cap.push_back(ch);
    if (done) n_done++;
    if (err) n_err++;
    if (busy && !ch_valid && !done && !err) n_stall++;
  end

  // ---------------- stimulus ----------------
  task automatic go(input logic [3:0] nt, input logic [31:0] dg, input logic [7:0] op);
    @(negedge clk);
    num_terms = nt; digits = dg; ops = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_cap(input string name, input byte unsigned exp[$]);
    chk({name, "_len"}, 32'(cap.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk(name, 32'(cap[i]), 32'(exp[i]));
  endtask

  initial begin
    byte unsigned s347[$] = '{8'h33, 8'h2B, 8'h34, 8'h2A, 8'h37};
    byte unsigned s9[$]   = '{8'h39};
    byte unsigned s4[$]   = '{8'h32, 8'h2A, 8'h31, 8'h2B, 8'h36, 8'h2A, 8'h35};
    byte unsigned none[$];
    int d0, e0, st0, k;
    logic [31:0] dg;
    int idx;

    repeat (2) @(negedge clk);
    chk("rst_ch", 32'(ch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    clr = 1'b0;
    @(negedge clk);

    // "3+4*7"
    cap.delete(); d0 = n_done;
    go(4'd3, 32'h0000_0743, 8'b0000_0010);
    wait_idle();
    chk_cap("s347", s347);
    chk("s347_done", 32'(n_done - d0), 32'd1);

    // single term
    cap.delete(); d0 = n_done;
    go(4'd1, 32'h0000_0009, 8'hFF);
    wait_idle();
    chk_cap("s9", s9);
    chk("s9_done", 32'(n_done - d0), 32'd1);

    // rejected requests
    cap.delete(); e0 = n_err;
    go(4'd2, 32'h0000_00A0, 8'h00); wait_idle();
    go(4'd0, 32'h0000_0011, 8'h00); wait_idle();
    go(4'(MAXT + 1), 32'h1111_1111, 8'h00); wait_idle();
    chk("rej_errs", 32'(n_err - e0), 32'd3);
    chk_cap("rej_chars", none);

    // hold for 3 cycles after '+'
    cap.delete(); st0 = n_stall;
    go(4'd3, 32'h0000_0743, 8'b0000_0010);
    @(negedge clk);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_idle();
    chk_cap("hold", s347);
    chk("hold_stalls", 32'(n_stall - st0), 32'd3);

    // start mid-transfer, then start during the done cycle
    cap.delete(); d0 = n_done;
    go(4'd3, 32'h0000_0743, 8'b0000_0010);
    num_terms = 4'd2; digits = 32'h0000_0011; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    chk("done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd0);
    chk_cap("ignore", s347);
    chk("ign_done", 32'(n_done - d0), 32'd1);

    // async clear during an operator of a 4-term transfer
    d0 = n_done;
    go(4'd4, 32'h0000_5612, 8'b0000_0101);
    k = 0;
    while (!(ch_valid && (ch == 8'h2B || ch == 8'h2A)) && k < 20) begin @(negedge clk); k++; end
    chk("op_seen", 32'(ch_valid), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_ch", 32'(ch), 32'h0);
    chk("clr_valid", 32'(ch_valid), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    @(negedge clk); clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("clr_nodone", 32'(n_done - d0), 32'd0);
    cap.delete();
    go(4'd4, 32'h0000_5612, 8'b0000_0101);
    wait_idle();
    chk_cap("after_clr", s4);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hold  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 3) == 0);
      num_terms = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, MAXT));
      dg = '0;
      for (int i = 0; i < MAXT; i++) dg |= 32'($urandom_range(0, 9)) << (4*i);
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, MAXT - 1));
        dg = (dg & ~(32'hF << (4*idx))) | (32'($urandom_range(10, 15)) << (4*idx));
      end
      digits = dg;
      ops = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
